uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx_pin  input  1  asynchronous UART RX line, idle high.
REQ-006 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-007 SHALL have port rx_data  output  8  last received byte, LSB first on the line.
REQ-008 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 SHALL have port rx_frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 SHALL have port rx_overrun  output  1  one-cycle pulse, new byte overwrote an unconsumed byte.
REQ-011 SHALL have port rx_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL use CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide; 234 at defaults) and HALF_BIT = CLKS_PER_BIT/2.
REQ-013 SHALL pass rx_pin through a 2-flop synchronizer (reset value 1); every later reference to "line" means the synchronizer output.
REQ-014 SHALL implement states IDLE, START, DATA, STOP with a 16-bit bit-period counter and a 3-bit bit index.
REQ-015 IDLE: counter and index held at 0; line low -> START.
REQ-016 START: count to HALF_BIT-1; there, line low -> counter cleared, DATA; line high -> IDLE (glitch rejected, no outputs change).
REQ-017 DATA: count to CLKS_PER_BIT-1; there, sample line into shift register bit [index], clear counter; index 7 -> STOP, else index+1.
REQ-018 STOP: count to CLKS_PER_BIT-1; there, sample line and return to IDLE the next cycle (mid-stop-bit, enabling resync on the next start edge).
REQ-019 Stop sample high: rx_data <= shift register, rx_valid <= 1 on the cycle after the sample.
REQ-020 Stop sample low: rx_frame_err pulses 1 cycle, rx_data and rx_valid unchanged.
REQ-021 rx_valid SHALL clear on the cycle after rx_valid && rx_ready, and otherwise hold.
REQ-022 Good stop with rx_valid=1 and rx_ready=0 in the same cycle: rx_data overwritten, rx_valid stays 1, rx_overrun pulses 1 cycle.
REQ-023 Good stop coincident with a rx_valid && rx_ready acceptance: new byte loaded, rx_valid stays 1, no overrun.
REQ-024 rx_data SHALL change only on a good stop, never mid-frame.

Reset
REQ-025 On rst_n low: state IDLE, counter 0, index 0, shift register 0, rx_data 0x00, rx_valid 0, rx_frame_err 0, rx_overrun 0, rx_busy 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL discard the partial byte; after release the receiver waits for a new falling edge on the line.

Configuration
REQ-027 With UART_RX_MAJORITY_EN defined, every START/DATA/STOP sample SHALL be the 2-of-3 majority of line values at counter targets -1, 0 and +1, with the decision taken at target+1 (all later timing shifts by +1 cycle; bit period unchanged).
REQ-028 Without UART_RX_MAJORITY_EN, each sample SHALL be the single line value at the counter target.

Structure
REQ-029 Package uart_pkg SHALL hold the IDLE/START/DATA/STOP state encodings (3-bit, 0..3) and a CLKS_PER_BIT computation shared with the transmitter.
REQ-030 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer; all other logic stays in uart_rx.

Verification
REQ-031 Defaults, send 0xA5 at 234 clk/bit, rx_ready=1 -> rx_data=0xA5, rx_valid high 1 cycle, no error pulses.
REQ-032 Line low for 50 cycles then high -> no rx_valid, no rx_frame_err, rx_busy returns low before cycle 120.
REQ-033 Send 0x3C with stop bit forced low -> rx_frame_err pulse, rx_valid stays 0, rx_data unchanged.
REQ-034 Back-to-back 0x00 then 0xFF, no idle gap, rx_ready=1 -> two rx_valid events with 0x00 then 0xFF.
REQ-035 rx_ready=0, send 0x11 then 0x22 -> rx_overrun pulse on the second stop, rx_data=0x22, rx_valid=1 until rx_ready.
REQ-036 Assert rst_n low during bit 4 of 0x55, release, send 0x81 -> only 0x81 delivered; repeat with UART_RX_MAJORITY_EN and a 1-cycle mid-bit glitch -> byte still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// UART shared definitions: receiver FSM state encodings and bit-period arithmetic.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } uart_state_t;

    // Clock cycles per serial bit; the transmitter uses the same divide so both ends agree.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer bringing the asynchronous RX pin into the clk domain.
// Latency: 2 clk cycles from pin to dout.
// Backpressure: none; flops reset to 1 so a reset never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    // Shift the raw pin through two flops to settle metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with one-byte holding register, framing-error and overrun pulses.
// Latency: rx_valid rises the cycle after the mid-stop-bit sample (+1 cycle with UART_RX_MAJORITY_EN).
// Backpressure: rx_ready only drains the holding register; an unconsumed byte is overwritten (rx_overrun).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    // With majority voting the decision lands one cycle after the nominal
    // sample point; reloading the counter with that lag keeps the bit period.
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_LAG = 1;
`else
    localparam int SAMPLE_LAG = 0;
`endif

    localparam logic [15:0] START_TGT  = 16'(HALF_BIT - 1 + SAMPLE_LAG);
    localparam logic [15:0] BIT_TGT    = 16'(CLKS_PER_BIT - 1 + SAMPLE_LAG);
    localparam logic [15:0] CNT_RELOAD = 16'(SAMPLE_LAG);

    logic        line;
    logic        sample_bit;
    uart_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  data_nxt;
    logic        valid_nxt, err_nxt, ovr_nxt;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (rx_pin),
        .dout  (line)
    );

`ifdef UART_RX_MAJORITY_EN
    logic line_d1, line_d2;

    // Keep the two previous line values so target-1, target and target+1 can vote.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_d1 <= 1'b1;
            line_d2 <= 1'b1;
        end else begin
            line_d1 <= line;
            line_d2 <= line_d1;
        end
    end

    assign sample_bit = (line & line_d1) | (line & line_d2) | (line_d1 & line_d2);
`else
    assign sample_bit = line;
`endif

    assign rx_busy = (state != IDLE);

    // State and datapath registers; everything is computed in the next-state block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            shreg        <= shreg_nxt;
            rx_data      <= data_nxt;
            rx_valid     <= valid_nxt;
            rx_frame_err <= err_nxt;
            rx_overrun   <= ovr_nxt;
        end
    end

    // Next-state, bit sampling and output-register updates.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        data_nxt  = rx_data;
        valid_nxt = rx_valid;
        err_nxt   = 1'b0;
        ovr_nxt   = 1'b0;

        if (rx_valid && rx_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = '0;
                if (!line) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == START_TGT) begin
                    if (!sample_bit) begin
                        cnt_nxt   = CNT_RELOAD;
                        state_nxt = DATA;
                    end else begin
                        // Start pulse shorter than half a bit: treat as noise.
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_TGT) begin
                    shreg_nxt[idx] = sample_bit;
                    cnt_nxt        = CNT_RELOAD;
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_TGT) begin
                    // Leave mid-stop-bit so the next start edge is caught promptly.
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (sample_bit) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                        ovr_nxt   = rx_valid && !rx_ready;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                idx_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
